// File: rtl/bcd_stopwatch_core_if.sv
// Button inputs and BCD display outputs of bcd_stopwatch_core.
// i_btn_lap exists only when BCD_STOPWATCH_LAP_EN is defined.
interface bcd_stopwatch_core_if;
    logic       i_btn_ss;
    logic       i_btn_clr;
`ifdef BCD_STOPWATCH_LAP_EN
    logic       i_btn_lap;
`endif
    logic [3:0] o_digit3;
    logic [3:0] o_digit2;
    logic [3:0] o_digit1;
    logic [3:0] o_digit0;
    logic       o_upd;
    logic       o_running;
    logic       o_overflow;

`ifdef BCD_STOPWATCH_LAP_EN
    modport master (output i_btn_ss, i_btn_clr, i_btn_lap,
                    input  o_digit3, o_digit2, o_digit1, o_digit0, o_upd, o_running, o_overflow);
    modport slave  (input  i_btn_ss, i_btn_clr, i_btn_lap,
                    output o_digit3, o_digit2, o_digit1, o_digit0, o_upd, o_running, o_overflow);
`else
    modport master (output i_btn_ss, i_btn_clr,
                    input  o_digit3, o_digit2, o_digit1, o_digit0, o_upd, o_running, o_overflow);
    modport slave  (input  i_btn_ss, i_btn_clr,
                    output o_digit3, o_digit2, o_digit1, o_digit0, o_upd, o_running, o_overflow);
`endif
endinterface

// File: rtl/bcd_stopwatch_core.sv
// 4-digit BCD stopwatch: button sync/edge detect, IDLE/RUN/PAUSE FSM, prescaler, BCD counter.
// Optional lap hold of the displayed digits under BCD_STOPWATCH_LAP_EN.
module bcd_stopwatch_core #(
    parameter int unsigned TICK_DIV = 1000000,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    bcd_stopwatch_core_if.slave bus
);
    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   CNT_MAX    = 16'h9999;
`ifdef BCD_STOPWATCH_LAP_EN
    localparam int unsigned   NB         = 3;
`else
    localparam int unsigned   NB         = 2;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2} state_t;

    state_t          r_state;
    logic            r_running;
    logic            r_overflow;
    logic            r_upd;
    logic [NB-1:0]   w_btn;
    logic [NB-1:0]   r_sync1;
    logic [NB-1:0]   r_sync2;
    logic [NB-1:0]   r_prev;
    logic [NB-1:0]   w_edge;
    logic [PW-1:0]   r_presc;
    logic [3:0][3:0] r_cnt;
    logic [3:0][3:0] w_cnt_inc;
    logic [3:0][3:0] w_cnt_next;
    logic [3:0][3:0] w_disp;
    logic            w_ss;
    logic            w_clr;
    logic            w_tick;
    logic            w_at_max;
    logic            w_sat_hit;
    logic            w_ss_ok;

`ifdef BCD_STOPWATCH_LAP_EN
    assign w_btn = {bus.i_btn_lap, bus.i_btn_clr, bus.i_btn_ss};
`else
    assign w_btn = {bus.i_btn_clr, bus.i_btn_ss};
`endif

    // Two-flop synchroniser plus previous-level flop for rising-edge detect
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= w_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    assign w_edge    = r_sync2 & ~r_prev;
    assign w_ss      = w_edge[0];
    assign w_clr     = w_edge[1];
    assign w_tick    = (r_state == S_RUN) && (r_presc == PRESC_LAST);
    assign w_at_max  = (r_cnt == CNT_MAX);
    assign w_sat_hit = SATURATE && w_tick && w_at_max;
    // A saturated stopwatch stays paused until cleared
    assign w_ss_ok   = w_ss && !(SATURATE && r_overflow);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else if (w_clr) begin
            r_state   <= S_IDLE;
            r_running <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ss) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (w_sat_hit || w_ss) begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (w_ss_ok) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                end
            endcase
        end
    end

    // BCD increment with ripple carry across digits
    always_comb begin
        logic carry;
        w_cnt_inc = r_cnt;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r_cnt[i] == 4'd9) begin
                    w_cnt_inc[i] = 4'd0;
                end else begin
                    w_cnt_inc[i] = r_cnt[i] + 4'd1;
                    carry        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_clr) begin
            w_cnt_next = '0;
        end else if (w_tick && !(SATURATE && w_at_max)) begin
            w_cnt_next = w_cnt_inc;
        end
    end

    // Prescaler holds its partial period across PAUSE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc    <= '0;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clr || (r_state == S_IDLE)) begin
                r_presc <= '0;
            end else if (r_state == S_RUN) begin
                r_presc <= w_tick ? '0 : r_presc + PW'(1);
            end
            r_cnt <= w_cnt_next;
            if (w_clr) begin
                r_overflow <= 1'b0;
            end else if (w_tick && w_at_max) begin
                r_overflow <= 1'b1;
            end else if (!SATURATE) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef BCD_STOPWATCH_LAP_EN
    logic            w_lap;
    logic            r_hold;
    logic            w_hold_next;
    logic            w_release;
    logic [3:0][3:0] r_disp;
    logic [3:0][3:0] w_disp_next;

    assign w_lap = w_edge[2] && (r_state != S_IDLE);

    always_comb begin
        w_hold_next = r_hold;
        if (w_clr) begin
            w_hold_next = 1'b0;
        end else if (w_lap) begin
            w_hold_next = !r_hold;
        end
        w_release   = r_hold && !w_hold_next && !w_clr;
        w_disp_next = w_hold_next ? r_disp : w_cnt_next;
    end

    // Display copy freezes while holding; the live count keeps running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= 1'b0;
            r_disp <= '0;
            r_upd  <= 1'b0;
        end else begin
            r_hold <= w_hold_next;
            r_disp <= w_disp_next;
            r_upd  <= w_release || (w_disp_next != r_disp);
        end
    end

    assign w_disp = r_disp;
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_upd <= 1'b0;
        end else begin
            r_upd <= (w_cnt_next != r_cnt);
        end
    end

    assign w_disp = r_cnt;
`endif

    assign bus.o_digit3   = w_disp[3];
    assign bus.o_digit2   = w_disp[2];
    assign bus.o_digit1   = w_disp[1];
    assign bus.o_digit0   = w_disp[0];
    assign bus.o_upd      = r_upd;
    assign bus.o_running  = r_running;
    assign bus.o_overflow = r_overflow;
endmodule
